pipelined_adder: RTL and testbench

//   Parametrised, pipelined carry-segmented adder/subtractor for the 64-bit datapath.

---
 rtl/pipelined_adder_pkg.sv | 24 ++
 rtl/adder_stage.sv | 117 +++++++++++
 rtl/pipelined_adder.sv | 108 ++++++++++
 tb/tb_pipelined_adder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared op type, segment arithmetic and configuration checks
package pipelined_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Width of one carry segment; a zero stage count falls back to one segment
    function automatic int seg_width(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

    // Legal configurations split WIDTH into STAGES equal, non-empty segments
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

    // Bit position of the least significant bit of segment idx
    function automatic int seg_lo(input int idx, input int seg_w);
        return idx * seg_w;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// rtl/adder_stage.sv - one carry segment of pipelined_adder with its valid, carry and skew registers
module adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int SEG_W   = 16,
    parameter int IDX     = 0
`ifdef PIPELINED_ADDER_FLAGS_EN
    ,
    parameter bit IS_LAST = 1'b1
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             valid_i,
    input  logic             carry_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    output logic             carry_o,
    output logic [WIDTH-1:0] word_o,
    output logic [WIDTH-1:0] b_o
`ifdef PIPELINED_ADDER_FLAGS_EN
    ,
    output logic             zero_o,
    output logic             neg_o,
    output logic             ovf_o
`endif
);
    localparam int LO = seg_lo(IDX, SEG_W);

    logic [SEG_W-1:0] seg_a;
    logic [SEG_W-1:0] seg_b;
    logic [SEG_W:0]   seg_sum;

    logic             valid_d, valid_q;
    logic             carry_d, carry_q;
    logic [WIDTH-1:0] word_d, word_q;
    logic [WIDTH-1:0] b_d, b_q;

    // Add this segment; word carries finished low sum bits and still-pending upper A bits
    always_comb begin
        seg_a   = word_i[LO +: SEG_W];
        seg_b   = b_i[LO +: SEG_W];
        seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_W{1'b0}}, carry_i};
        valid_d = valid_q;
        carry_d = carry_q;
        word_d  = word_q;
        b_d     = b_q;
        if (en) begin
            valid_d              = valid_i;
            carry_d              = seg_sum[SEG_W];
            word_d               = word_i;
            word_d[LO +: SEG_W]  = seg_sum[SEG_W-1:0];
            b_d                  = b_i;
        end
    end

    // Stage registers hold as a whole whenever the pipe is stalled, bubbles included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            word_q  <= '0;
            b_q     <= '0;
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            word_q  <= word_d;
            b_q     <= b_d;
        end
    end

    assign valid_o = valid_q;
    assign carry_o = carry_q;
    assign word_o  = word_q;
    assign b_o     = b_q;

`ifdef PIPELINED_ADDER_FLAGS_EN
    logic msb_cin;
    logic zero_d, zero_q;
    logic neg_d, neg_q;
    logic ovf_d, ovf_q;

    // Only the MSB segment sees the complete sum and the carry into bit WIDTH-1
    always_comb begin
        msb_cin = seg_a[SEG_W-1] ^ seg_b[SEG_W-1] ^ seg_sum[SEG_W-1];
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        if (en && IS_LAST) begin
            zero_d = (word_d == '0);
            neg_d  = word_d[WIDTH-1];
            ovf_d  = msb_cin ^ seg_sum[SEG_W];
        end
    end

    // Flags are registered with the same enable so they stay aligned with the sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign zero_o = zero_q;
    assign neg_o  = neg_q;
    assign ovf_o  = ovf_q;
`endif

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined carry-segmented add/sub; PIPELINED_ADDER_FLAGS_EN adds zero/neg/ovf outputs
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef PIPELINED_ADDER_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf
`endif
);
    localparam int SEG_W = seg_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    op_e              op;
    logic             advance;
    logic             c_eff;
    logic [WIDTH-1:0] b_eff;

    logic [STAGES:0]            valid_w;
    logic [STAGES:0]            carry_w;
    logic [STAGES:0][WIDTH-1:0] word_w;
    logic [STAGES:0][WIDTH-1:0] b_w;
    logic                       unused_b;

    // Operand conditioning and the global stall: the pipe moves only when the output slot can drain
    always_comb begin
        op      = in_sub ? OP_SUB : OP_ADD;
        b_eff   = (op == OP_SUB) ? ~in_b : in_b;
        c_eff   = in_cin ^ (op == OP_SUB);
        advance = out_ready | ~out_valid;
    end

    assign in_ready   = advance;
    assign valid_w[0] = in_valid & advance;
    assign carry_w[0] = c_eff;
    assign word_w[0]  = in_a;
    assign b_w[0]     = b_eff;

`ifdef PIPELINED_ADDER_FLAGS_EN
    logic [STAGES-1:0] zero_w;
    logic [STAGES-1:0] neg_w;
    logic [STAGES-1:0] ovf_w;
    logic              unused_flags;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .WIDTH   (WIDTH),
            .SEG_W   (SEG_W),
            .IDX     (k)
`ifdef PIPELINED_ADDER_FLAGS_EN
            ,
            .IS_LAST (k == STAGES - 1)
`endif
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (advance),
            .valid_i (valid_w[k]),
            .carry_i (carry_w[k]),
            .word_i  (word_w[k]),
            .b_i     (b_w[k]),
            .valid_o (valid_w[k+1]),
            .carry_o (carry_w[k+1]),
            .word_o  (word_w[k+1]),
            .b_o     (b_w[k+1])
`ifdef PIPELINED_ADDER_FLAGS_EN
            ,
            .zero_o  (zero_w[k]),
            .neg_o   (neg_w[k]),
            .ovf_o   (ovf_w[k])
`endif
        );
    end

    assign out_valid = valid_w[STAGES];
    assign out_cout  = carry_w[STAGES];
    assign out_sum   = word_w[STAGES];
    // The B skew register leaving the last stage has no consumer
    assign unused_b  = ^b_w[STAGES];

`ifdef PIPELINED_ADDER_FLAGS_EN
    assign out_zero     = zero_w[STAGES-1];
    assign out_neg      = neg_w[STAGES-1];
    assign out_ovf      = ovf_w[STAGES-1];
    assign unused_flags = ^{zero_w, neg_w, ovf_w};
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder (64/4, 32/2, 32/1)
module tb_pipelined_adder;

    localparam int N_DUT = 3;
    localparam int DW [N_DUT] = '{64, 32, 32};
    localparam int DS [N_DUT] = '{4, 2, 1};

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        zero;
        logic        neg;
        logic        ovf;
        int          target;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_cin = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;

    logic        rdy64, rdy2, rdy1, v64, v2, v1, c64, c2, c1;
    logic [63:0] s64;
    logic [31:0] s2, s1;
`ifdef PIPELINED_ADDER_FLAGS_EN
    logic        z64, z2, z1, n64, n2, n1, o64, o2, o1;
`endif

    int   checks = 0;
    int   failures = 0;
    int   mode = 0;
    int   phase = 0;
    exp_t mq [N_DUT][$];
    int   adv_cnt [N_DUT];
    int   retired [N_DUT];

    logic        act_v [N_DUT];
    logic        act_r [N_DUT];
    logic        act_c [N_DUT];
    logic [63:0] act_s [N_DUT];
    logic        act_z [N_DUT];
    logic        act_n [N_DUT];
    logic        act_o [N_DUT];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(64), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(v64), .out_ready(out_ready), .out_sum(s64), .out_cout(c64)
`ifdef PIPELINED_ADDER_FLAGS_EN
        , .out_zero(z64), .out_neg(n64), .out_ovf(o64)
`endif
    );

    pipelined_adder #(.WIDTH(32), .STAGES(2)) dut_w32_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(v2), .out_ready(out_ready), .out_sum(s2), .out_cout(c2)
`ifdef PIPELINED_ADDER_FLAGS_EN
        , .out_zero(z2), .out_neg(n2), .out_ovf(o2)
`endif
    );

    pipelined_adder #(.WIDTH(32), .STAGES(1)) dut_w32_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(v1), .out_ready(out_ready), .out_sum(s1), .out_cout(c1)
`ifdef PIPELINED_ADDER_FLAGS_EN
        , .out_zero(z1), .out_neg(n1), .out_ovf(o1)
`endif
    );

    always_comb begin
        act_v[0] = v64;  act_v[1] = v2;  act_v[2] = v1;
        act_r[0] = rdy64; act_r[1] = rdy2; act_r[2] = rdy1;
        act_c[0] = c64;  act_c[1] = c2;  act_c[2] = c1;
        act_s[0] = s64;  act_s[1] = {32'd0, s2}; act_s[2] = {32'd0, s1};
`ifdef PIPELINED_ADDER_FLAGS_EN
        act_z[0] = z64; act_z[1] = z2; act_z[2] = z1;
        act_n[0] = n64; act_n[1] = n2; act_n[2] = n1;
        act_o[0] = o64; act_o[1] = o2; act_o[2] = o1;
`else
        for (int d = 0; d < N_DUT; d++) begin
            act_z[d] = 1'b0; act_n[d] = 1'b0; act_o[d] = 1'b0;
        end
`endif
    end

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: plain W-bit add of a, (optionally inverted) b and effective carry
    function automatic exp_t ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, input logic sub);
        exp_t        r;
        logic [63:0] mask, am, bm, sm;
        logic [64:0] full;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am     = a & mask;
        bm     = (sub ? ~b : b) & mask;
        full   = {1'b0, am} + {1'b0, bm} + {64'd0, cin ^ sub};
        sm     = full[63:0] & mask;
        r.sum  = sm;
        r.cout = full[w];
        r.zero = (sm == 64'd0);
        r.neg  = sm[w-1];
        r.ovf  = (am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]);
        r.target = 0;
        return r;
    endfunction

    function automatic bit exp_valid(input int d);
        return (mq[d].size() > 0) && (mq[d][0].target == adv_cnt[d]);
    endfunction

    // Pipeline model: whole pipe advances together; an op is visible after DS advancing edges
    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        bit   ev;
        if (!rst_n) begin
            for (int d = 0; d < N_DUT; d++) begin
                mq[d].delete();
                adv_cnt[d] = 0;
            end
        end else begin
            for (int d = 0; d < N_DUT; d++) begin
                ev = exp_valid(d);
                if (out_ready || !ev) begin
                    adv_cnt[d]++;
                    if (ev) begin
                        void'(mq[d].pop_front());
                        retired[d]++;
                    end
                    if (in_valid) begin
                        e = ref_op(DW[d], in_a, in_b, in_cin, in_sub);
                        e.target = adv_cnt[d] + DS[d] - 1;
                        mq[d].push_back(e);
                    end
                end
            end
        end
    end

    logic        prev_hold = 1'b0;
    logic [63:0] prev_sum = '0;
    logic        prev_cout = 1'b0;

    // Compare every DUT against the model on every cycle out of reset
    always @(negedge clk) begin
        bit   ev;
        exp_t f;
        if (rst_n) begin
            for (int d = 0; d < N_DUT; d++) begin
                ev = exp_valid(d);
                check(act_v[d] === ev, $sformatf("out_valid_dut%0d", d), 64'(act_v[d]), 64'(ev));
                check(act_r[d] === (out_ready | ~ev), $sformatf("in_ready_dut%0d", d),
                      64'(act_r[d]), 64'(out_ready | ~ev));
                if (ev) begin
                    f = mq[d][0];
                    check(act_s[d] === f.sum, $sformatf("out_sum_dut%0d", d), act_s[d], f.sum);
                    check(act_c[d] === f.cout, $sformatf("out_cout_dut%0d", d), 64'(act_c[d]), 64'(f.cout));
`ifdef PIPELINED_ADDER_FLAGS_EN
                    check(act_z[d] === f.zero, $sformatf("out_zero_dut%0d", d), 64'(act_z[d]), 64'(f.zero));
                    check(act_n[d] === f.neg, $sformatf("out_neg_dut%0d", d), 64'(act_n[d]), 64'(f.neg));
                    check(act_o[d] === f.ovf, $sformatf("out_ovf_dut%0d", d), 64'(act_o[d]), 64'(f.ovf));
`endif
                end
            end
            if (prev_hold) begin
                check(v64 === 1'b1 && s64 === prev_sum && c64 === prev_cout, "stall_hold",
                      s64, prev_sum);
            end
            prev_hold = v64 & ~out_ready;
            prev_sum  = s64;
            prev_cout = c64;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // out_ready source: 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 held low
    always @(posedge clk) begin
        #1;
        phase++;
        case (mode)
            1:       out_ready = (phase % 4 == 0) || (phase % 4 == 3);
            2:       out_ready = ($urandom_range(0, 2) != 0);
            3:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        bit r;
        int n;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            r = rdy64;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 200) begin
                check(1'b0, "send_timeout", 64'(n), 64'd200);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic directed(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub,
                            input logic [63:0] es, input logic ec, input logic ez, input logic en,
                            input logic eo, input string nm);
        int k;
        send(a, b, cin, sub);
        k = 1;
        @(negedge clk);
        while (!v64 && k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check(v64 === 1'b1 && k == 4, {nm, "_latency"}, 64'(k), 64'd4);
        check(s64 === es, {nm, "_sum"}, s64, es);
        check(c64 === ec, {nm, "_cout"}, 64'(c64), 64'(ec));
`ifdef PIPELINED_ADDER_FLAGS_EN
        check(z64 === ez && n64 === en && o64 === eo, {nm, "_flags"},
              64'({z64, n64, o64}), 64'({ez, en, eo}));
`else
        if (ez && en && eo) $display("note: %s flag expectations unused", nm);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq[0].size() + mq[1].size() + mq[2].size()) > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check(n < 300, "drain_timeout", 64'(n), 64'd300);
        #1;
    endtask

    initial begin
        int base;
        for (int d = 0; d < N_DUT; d++) retired[d] = 0;
        #12;
        check(v64 === 1'b0, "reset_out_valid", 64'(v64), 64'd0);
        check(s64 === 64'd0, "reset_out_sum", s64, 64'd0);
        check(c64 === 1'b0, "reset_out_cout", 64'(c64), 64'd0);
`ifdef PIPELINED_ADDER_FLAGS_EN
        check({z64, n64, o64} === 3'b000, "reset_flags", 64'({z64, n64, o64}), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check(rdy64 === 1'b1, "in_ready_after_reset", 64'(rdy64), 64'd1);
        @(posedge clk);
        #1;

        directed(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, "all_ones_plus_1");
        directed(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, "sub_5_7");
        directed(64'd10, 64'd3, 1'b1, 1'b1, 64'd6, 1'b1, 1'b0, 1'b0, 1'b0, "sub_10_3_cin");
        directed(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0,
                 1'b0, 1'b0, 1'b0, "seg0_carry");
        directed(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0,
                 1'b0, 1'b1, 1'b1, "signed_ovf");
        directed(64'h1234_0000_0000_0000, 64'h0000_5678_0000_0000, 1'b1, 1'b0,
                 64'h1234_5678_0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, "cin_add");
        drain();

        mode = 1;
        base = retired[0];
        for (int i = 0; i < 10; i++) begin
            send(64'h0123_4567_89AB_CDEF * 64'(i + 1), 64'(i + 3) << (16 * (i % 4)),
                 1'(i >> 1), 1'(i));
        end
        mode = 0;
        drain();
        check(retired[0] - base == 10, "stream_count", 64'(retired[0] - base), 64'd10);

        mode = 3;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(64'(100 + i), 64'(i), 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        check(v64 === 1'b1, "pre_reset_valid", 64'(v64), 64'd1);
        rst_n = 1'b0;
        #1;
        check(v64 === 1'b0, "async_reset_valid", 64'(v64), 64'd0);
        check(s64 === 64'd0, "async_reset_sum", s64, 64'd0);
        mode = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check(v64 === 1'b0, "no_stale_after_reset", 64'(v64), 64'd0);

        mode = 2;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        mode = 0;
        drain();
        check(retired[2] > 100, "random_w32_s1_count", 64'(retired[2]), 64'd100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
